// File: rtl/quad_decoder_counter_if.sv
// Purpose : bundles encoder pins, control strobes and position outputs of the quadrature decoder.
// Latency : none (wiring only).
// Backpressure: none; encoder pins are free-running and the outputs are level/pulse signals.
// Ports   : enc_a/enc_b/enc_z async phases; idx_clr_en, clr, err_clr controls;
//           pos, dir, step, err status. master = driver of the pins, slave = decoder.
interface quad_decoder_counter_if #(
  parameter int WIDTH = 16
);
  logic             enc_a;
  logic             enc_b;
  logic             enc_z;
  logic             idx_clr_en;
  logic             clr;
  logic             err_clr;
  logic [WIDTH-1:0] pos;
  logic             dir;
  logic             step;
  logic             err;

  modport master (
    output enc_a, enc_b, enc_z, idx_clr_en, clr, err_clr,
    input  pos, dir, step, err
  );

  modport slave (
    input  enc_a, enc_b, enc_z, idx_clr_en, clr, err_clr,
    output pos, dir, step, err
  );
endinterface

// File: rtl/quad_decoder_counter.sv
// Purpose : 4x quadrature decoder (A/B + index Z) with synchronizer, glitch filter and wrapping position counter.
// Latency : encoder edge to pos/step = SYNC_STAGES + FILT_CYCLES + 1 clk edges.
// Backpressure: none; every legal step is counted, illegal double-bit transitions set sticky err.
// Ports   : clk, rst_n (async active-low); bus (slave modport) carries encoder pins,
//           idx_clr_en/clr/err_clr controls and pos/dir/step/err outputs.
module quad_decoder_counter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  quad_decoder_counter_if.slave       bus
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYCLES - 1);
  localparam logic [CW-1:0] FILT_ONE  = CW'(1);
  // Decoding stays disabled until the reset values flushed out of the
  // sync/filter chain have been replaced by the real pin levels; otherwise an
  // encoder resting at 11 would look like an illegal 00->11 jump.
  localparam int SETTLE = SYNC_STAGES + FILT_CYCLES + 1;
  localparam int SW     = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
  localparam logic [SW-1:0] SET_ONE  = SW'(1);

  // Bit order everywhere: [2]=A, [1]=B, [0]=Z.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  synced;
  logic [2:0]                  filt_q, filt_d;
  logic [2:0][CW-1:0]          fcnt_q, fcnt_d;
  logic [SW-1:0]               settle_q, settle_d;
  logic                        init;
  logic [1:0]                  prev_ab_q;
  logic                        z_prev_q;
  logic [WIDTH-1:0]            pos_q, pos_d;
  logic                        dir_q, dir_d;
  logic                        step_q, step_d;
  logic                        err_q, err_d;
  logic                        up, down, illegal, idx_hit;
  logic [1:0]                  ph_diff;

  // Gray sequence 00->10->11->01 mapped onto an incrementing phase.
  function automatic logic [1:0] ab2ph(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  assign synced = sync_q[SYNC_STAGES-1];
  assign init   = (settle_q == SETTLE_V);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (synced[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) filt_d[i] = synced[i];
        else                        fcnt_d[i] = fcnt_q[i] + FILT_ONE;
      end
    end
  end

  always_comb begin
    settle_d = init ? settle_q : settle_q + SET_ONE;
    ph_diff  = ab2ph(filt_q[2:1]) - ab2ph(prev_ab_q);
    up       = init && (ph_diff == 2'd1);
    down     = init && (ph_diff == 2'd3);
    illegal  = init && (ph_diff == 2'd2);
    idx_hit  = init && bus.idx_clr_en && filt_q[0] && !z_prev_q;

    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    err_d  = err_q;

    if (up)   dir_d = 1'b1;
    if (down) dir_d = 1'b0;

    // Clears take the position and suppress the step pulse, but direction still follows.
    if (bus.clr || idx_hit) begin
      pos_d = '0;
    end else if (up) begin
      pos_d  = pos_q + WIDTH'(1);
      step_d = 1'b1;
    end else if (down) begin
      pos_d  = pos_q - WIDTH'(1);
      step_d = 1'b1;
    end

    if (illegal)          err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      filt_q    <= '0;
      fcnt_q    <= '0;
      settle_q  <= '0;
      prev_ab_q <= '0;
      z_prev_q  <= 1'b0;
      pos_q     <= '0;
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync_q[0] <= {bus.enc_a, bus.enc_b, bus.enc_z};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      settle_q  <= settle_d;
      prev_ab_q <= filt_q[2:1];
      z_prev_q  <= filt_q[0];
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
    end
  end

  assign bus.pos  = pos_q;
  assign bus.dir  = dir_q;
  assign bus.step = step_q;
  assign bus.err  = err_q;

endmodule
